// File: rtl/fp_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl_pkg
// Shared definitions for the FP issue controller:
//   - FP op encodings carried on FPOpTypeE / FPUOp
//   - controller state encoding
//   - default per-op latencies
//   - lat_sel(): maps an op code to its FPU latency
// -----------------------------------------------------------------------------
package fp_issue_ctrl_pkg;

    // FP op encodings as seen on FPOpTypeE / FPUOp
    localparam logic [1:0] FP_ADD = 2'b00;
    localparam logic [1:0] FP_SUB = 2'b01;
    localparam logic [1:0] FP_MUL = 2'b10;
    localparam logic [1:0] FP_DIV = 2'b11;

    // Default FPU latencies (cycles from start to result-valid)
    localparam int LAT_ADD_DEF = 3;
    localparam int LAT_MUL_DEF = 4;
    localparam int LAT_DIV_DEF = 12;
    localparam int CNT_W_DEF   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Select the FPU latency for an op; FSUB shares the adder pipeline.
    function automatic int lat_sel(input logic [1:0] op,
                                   input int         lat_add,
                                   input int         lat_mul,
                                   input int         lat_div);
        int lat;
        case (op)
            FP_ADD:  lat = lat_add;
            FP_SUB:  lat = lat_add;
            FP_MUL:  lat = lat_mul;
            FP_DIV:  lat = lat_div;
            default: lat = lat_add;
        endcase
        return lat;
    endfunction

endpackage : fp_issue_ctrl_pkg

// File: rtl/fp_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl_if
// Bundle between the EX stage / hazard unit / FPU and the FP issue controller.
//   Pipeline -> controller : FPOpE, FPOpTypeE, FRdE, KillFP
//   Controller -> pipeline : FPUStart, FPUOp, StallFP, FPResultValid,
//                            FPRdOut, FPBusy
// The master modport is the pipeline side, the slave modport is the
// controller.
// -----------------------------------------------------------------------------
interface fp_issue_ctrl_if;

    logic       FPOpE;
    logic [1:0] FPOpTypeE;
    logic [4:0] FRdE;
    logic       KillFP;

    logic       FPUStart;
    logic [1:0] FPUOp;
    logic       StallFP;
    logic       FPResultValid;
    logic [4:0] FPRdOut;
    logic       FPBusy;

    modport master (
        output FPOpE,
        output FPOpTypeE,
        output FRdE,
        output KillFP,
        input  FPUStart,
        input  FPUOp,
        input  StallFP,
        input  FPResultValid,
        input  FPRdOut,
        input  FPBusy
    );

    modport slave (
        input  FPOpE,
        input  FPOpTypeE,
        input  FRdE,
        input  KillFP,
        output FPUStart,
        output FPUOp,
        output StallFP,
        output FPResultValid,
        output FPRdOut,
        output FPBusy
    );

endinterface : fp_issue_ctrl_if

// File: rtl/fp_issue_ctrl_lat_counter.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl_lat_counter
// Down-counter timing the FPU latency.
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high; clears the count
//   load_i     in   load load_val_i (start of an op)
//   load_val_i in   CNT_W value to load (LAT-1)
//   dec_i      in   decrement by one
//   clr_i      in   clear the count (op aborted)
//   last_o     out  count == 1: the current EXEC cycle is the last one
// -----------------------------------------------------------------------------
module fp_issue_ctrl_lat_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic             last_o
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next-count selection; clear has priority over load, load over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_ZERO;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_ONE);

endmodule : fp_issue_ctrl_lat_counter

// File: rtl/fp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl
// Sequences the fixed-latency multi-cycle FPU hanging off the EX stage.
// An FP op in EX (IDLE) gets a one-cycle FPUStart and StallFP is raised for
// exactly LAT cycles; in the following cycle (DONE) FPResultValid pulses with
// the latched destination register, and the FSM returns to IDLE so the next
// op can start one cycle later (issue interval LAT+1).
//   clk    in       clock, rising edge
//   reset  in       synchronous, active-high
//   fp     slave    FPOpE/FPOpTypeE/FRdE/KillFP in,
//                   FPUStart/FPUOp/StallFP/FPResultValid/FPRdOut/FPBusy out
// FPUStart and StallFP are combinational on the start cycle because the
// pipeline must freeze in the very cycle the op is seen in EX. All outputs
// are forced to 0 while reset is asserted.
// -----------------------------------------------------------------------------
module fp_issue_ctrl
    import fp_issue_ctrl_pkg::*;
#(
    parameter int LAT_ADD = LAT_ADD_DEF,
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int LAT_DIV = LAT_DIV_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    fp_issue_ctrl_if.slave fp
);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       op_q;
    logic [1:0]       op_d;
    logic [4:0]       rd_q;
    logic [4:0]       rd_d;

    logic             start_s;
    logic             stall_s;
    logic             valid_s;
    logic [1:0]       op_out_s;
    logic [4:0]       rd_out_s;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             cnt_clr_s;
    logic             cnt_last_s;
    logic [CNT_W-1:0] cnt_init_s;

    // Counter preload is LAT-1: the start cycle itself is the first stall cycle.
    always_comb begin
        cnt_init_s = CNT_W'(lat_sel(fp.FPOpTypeE, LAT_ADD, LAT_MUL, LAT_DIV) - 32'sd1);
    end

    fp_issue_ctrl_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_init_s),
        .dec_i      (cnt_dec_s),
        .clr_i      (cnt_clr_s),
        .last_o     (cnt_last_s)
    );

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        start_s    = 1'b0;
        stall_s    = 1'b0;
        valid_s    = 1'b0;
        op_out_s   = 2'b00;
        rd_out_s   = 5'd0;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        cnt_clr_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fp.FPOpE && !fp.KillFP) begin
                    start_s    = 1'b1;
                    stall_s    = 1'b1;
                    op_out_s   = fp.FPOpTypeE;
                    rd_out_s   = fp.FRdE;
                    op_d       = fp.FPOpTypeE;
                    rd_d       = fp.FRdE;
                    cnt_load_s = 1'b1;
                    state_d    = ST_EXEC;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_EXEC: begin
                op_out_s = op_q;
                rd_out_s = rd_q;
                if (fp.KillFP) begin
                    // Abort: release the pipeline this cycle, never report a result.
                    cnt_clr_s = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_last_s) begin
                    stall_s   = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    stall_s   = 1'b1;
                    cnt_dec_s = 1'b1;
                    state_d   = ST_EXEC;
                end
            end
            ST_DONE: begin
                // The retiring op still sits in EX with FPOpE high; it must not
                // restart, and a late KillFP cannot revoke the committed result.
                op_out_s = op_q;
                rd_out_s = rd_q;
                valid_s  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched op/rd registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 2'b00;
            rd_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
        end
    end

    assign fp.FPUStart      = start_s & ~reset;
    assign fp.StallFP       = stall_s & ~reset;
    assign fp.FPResultValid = valid_s & ~reset;
    assign fp.FPUOp         = reset ? 2'b00 : op_out_s;
    assign fp.FPRdOut       = reset ? 5'd0  : rd_out_s;
    assign fp.FPBusy        = (state_q != ST_IDLE) & ~reset;

endmodule : fp_issue_ctrl

// File: tb/tb_fp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fp_issue_ctrl
// Directed bench for fp_issue_ctrl (LAT_ADD=3, LAT_MUL=4, LAT_DIV=12).
// Observed vector layout: {FPUStart, FPUOp[1:0], StallFP, FPResultValid,
// FPRdOut[4:0], FPBusy}. Inputs change 1 time unit after the rising edge and
// outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_fp_issue_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fp_issue_ctrl_if bus ();

    fp_issue_ctrl #(
        .LAT_ADD (3),
        .LAT_MUL (4),
        .LAT_DIV (12),
        .CNT_W   (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fp    (bus)
    );

    logic [10:0] obs;
    assign obs = {bus.FPUStart, bus.FPUOp, bus.StallFP, bus.FPResultValid,
                  bus.FPRdOut, bus.FPBusy};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one op from T0 through its DONE cycle (T0+lat), FPOpE held high.
    task automatic drive_op(input string name, input logic [1:0] op,
                            input logic [4:0] rd, input int lat,
                            input logic kill_done);
        logic [10:0] exp;
        for (int k = 0; k <= lat; k++) begin
            step();
            bus.FPOpE     = 1'b1;
            bus.FPOpTypeE = op;
            bus.FRdE      = rd;
            bus.KillFP    = (k == lat) ? kill_done : 1'b0;
            if (k == 0)
                exp = {1'b1, op, 1'b1, 1'b0, rd, 1'b0};
            else if (k < lat)
                exp = {1'b0, op, 1'b1, 1'b0, rd, 1'b1};
            else
                exp = {1'b0, op, 1'b0, 1'b1, rd, 1'b1};
            #1;
            n_checks++;
            if (obs !== exp) begin
                $display("FAIL %s T0+%0d: got %b expected %b", name, k, obs, exp);
                n_fail++;
            end
        end
    endtask

    // One cycle with a non-FP instruction in EX; expects everything idle.
    task automatic idle_cycle(input string name);
        step();
        bus.FPOpE  = 1'b0;
        bus.KillFP = 1'b0;
        #1;
        n_checks++;
        if (obs !== 11'b0) begin
            $display("FAIL %s: got %b expected %b", name, obs, 11'b0);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.FPOpE     = 1'b1;
        bus.FPOpTypeE = 2'b11;
        bus.FRdE      = 5'd9;
        bus.KillFP    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            #1;
            n_checks++;
            if (obs !== 11'b0) begin
                $display("FAIL reset cycle %0d: got %b expected %b", k, obs, 11'b0);
                n_fail++;
            end
        end
        step();
        reset     = 1'b0;
        bus.FPOpE = 1'b0;
        #1;
        n_checks++;
        if (obs !== 11'b0) begin
            $display("FAIL reset_release: got %b expected %b", obs, 11'b0);
            n_fail++;
        end
    endtask

    // FADD rd=7: start at T0, stall T0..T2, result at T3. KillFP in DONE ignored.
    task automatic test_fadd();
        drive_op("fadd", 2'b00, 5'd7, 3, 1'b1);
        idle_cycle("fadd_after");
    endtask

    task automatic test_fdiv();
        drive_op("fdiv", 2'b11, 5'd31, 12, 1'b0);
        idle_cycle("fdiv_after");
    endtask

    // FMUL then FSUB with FPOpE held: second start exactly at T0+5.
    task automatic test_back_to_back();
        drive_op("b2b_fmul", 2'b10, 5'd4, 4, 1'b0);
        drive_op("b2b_fsub", 2'b01, 5'd21, 3, 1'b0);
        idle_cycle("b2b_after");
    endtask

    task automatic test_kill();
        logic [10:0] mask;
        logic [10:0] exp;
        mask = 11'b1_00_1_1_00000_1;
        step();
        bus.FPOpE = 1'b1; bus.FPOpTypeE = 2'b10; bus.FRdE = 5'd12; bus.KillFP = 1'b0;
        #1;
        exp = {1'b1, 2'b10, 1'b1, 1'b0, 5'd12, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL kill T0: got %b expected %b", obs, exp);
            n_fail++;
        end
        step();
        #1;
        exp = {1'b0, 2'b10, 1'b1, 1'b0, 5'd12, 1'b1};
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL kill T0+1: got %b expected %b", obs, exp);
            n_fail++;
        end
        step();
        bus.KillFP = 1'b1; bus.FPOpE = 1'b0;
        #1;
        exp = 11'b0_00_0_0_00000_1;
        n_checks++;
        if ((obs & mask) !== exp) begin
            $display("FAIL kill T0+2: got %b expected %b (masked)", obs & mask, exp);
            n_fail++;
        end
        for (int k = 3; k <= 6; k++) idle_cycle("kill_no_result");
        // Kill while the op is first seen in IDLE: nothing starts.
        step();
        bus.FPOpE = 1'b1; bus.FPOpTypeE = 2'b00; bus.FRdE = 5'd5; bus.KillFP = 1'b1;
        #1;
        n_checks++;
        if (obs !== 11'b0) begin
            $display("FAIL kill_idle: got %b expected %b", obs, 11'b0);
            n_fail++;
        end
        idle_cycle("kill_idle_after");
    endtask

    task automatic test_reset_mid_op();
        logic [10:0] exp;
        step();
        bus.FPOpE = 1'b1; bus.FPOpTypeE = 2'b00; bus.FRdE = 5'd18; bus.KillFP = 1'b0;
        #1;
        exp = {1'b1, 2'b00, 1'b1, 1'b0, 5'd18, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL rst_mid T0: got %b expected %b", obs, exp);
            n_fail++;
        end
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== 11'b0) begin
            $display("FAIL rst_mid T0+1: got %b expected %b", obs, 11'b0);
            n_fail++;
        end
        step();
        reset = 1'b0;
        bus.FPOpE = 1'b0;
        #1;
        n_checks++;
        if (obs !== 11'b0) begin
            $display("FAIL rst_mid T0+2: got %b expected %b", obs, 11'b0);
            n_fail++;
        end
        for (int k = 3; k <= 4; k++) idle_cycle("rst_mid_no_result");
        drive_op("rst_mid_restart", 2'b10, 5'd3, 4, 1'b0);
        idle_cycle("rst_mid_restart_after");
    endtask

    initial begin
        test_reset();
        test_fadd();
        test_fdiv();
        test_back_to_back();
        test_kill();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fp_issue_ctrl
